mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares one byte-wide synchronous RAM port between instruction fetch (IF) and load/store (MEM).
- Serialises each 8/16/32-bit access into byte cycles and assembles read data little-endian.
- Raises the per-stage stall requests consumed by the pipeline stall controller.
- Sits between the IF/MEM stages and the external RAM.

## Interface

Parameters:
- ADDR_W, 32, byte address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until if_done.
- if_addr  in  ADDR_W  IF word address.
- if_rdata  out  32  fetched instruction; valid while if_done.
- if_done  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  access length: 00 = byte, 01 = half, 10 or 11 = word.
- mem_addr  in  ADDR_W  MEM byte address.
- mem_wdata  in  32  store data; low bytes used first.
- mem_rdata  out  32  load data, zero-extended; valid while mem_done.
- mem_done  out  1  one-cycle completion pulse for MEM.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte; valid one cycle after ram_addr.
- ram_we  out  1  RAM write enable.
- stallreq_if  out  1  IF stall request.
- stallreq_mem  out  1  MEM stall request.

## Operation

States:
- IDLE: arbitrate.
- RD: issue one read address per cycle; capture the byte returned one cycle later.
- WR: drive one write byte per cycle.
- FIN: pulse done.

Grant:
- Arbitration happens only in IDLE, at a clock edge.
- At grant, latch the requester id, address, length n (1/2/4 bytes), we and wdata. IF is always a 4-byte read.
- Without a request, remain in IDLE.

RD:
- Byte counter k runs 0..n-1. Drive ram_addr = base+k, ram_we = 0.
- ram_din captured in the following cycle goes into rdata byte k, i.e. bits [8k+7:8k].
- Unfetched upper bytes are 0.
- After the last byte is captured, go to FIN.

WR:
- Drive ram_addr = base+k, ram_dout = wdata[8k+7:8k], ram_we = 1 for k = 0..n-1.
- Then go to FIN.

FIN:
- Pulse the granted requester's done for one cycle; the other done stays 0.
- Present rdata on that requester's rdata output.
- Return to IDLE. Requests are not sampled in FIN.

General rules:
- Each done completes exactly the transaction latched at grant.
- req still high in IDLE after FIN is a new transaction.
- stallreq_x = x_req & ~x_done, combinational; forced 0 while rst_n is low.
- Address arithmetic wraps: 0xFFFF_FFFF + 1 = 0x0000_0000.
- No alignment check.
- ram_we is 0 outside WR. ram_addr and ram_dout hold their last value when idle.

## Timing

Take cycle 0 as the IDLE cycle in which the request is sampled at its closing edge.

Word read:
- Addresses driven in cycles 1-4.
- Bytes captured at the ends of cycles 2-5.
- done and rdata in cycle 6.
- Latency from grant: 6 cycles.

Reads in general:
- n-byte read: done in cycle n+2.

Writes:
- n-byte write: ram_we in cycles 1..n, done in cycle n+1. A word store is done in cycle 5.

Throughput:
- The next grant is earliest in the cycle after FIN.
- Back-to-back word fetches: one per 7 cycles.

Reset:
- All outputs are 0: rdata, done, ram_addr, ram_dout, ram_we, stallreq.
- State goes to IDLE and the RR pointer goes to "IF last".
- Assertion mid-transaction abandons it immediately: no done, no further RAM writes. Partial writes already made remain.

## Configuration

MEM_ARB_RR_EN:
- Undefined: fixed priority. If both requests are high in IDLE, MEM wins; IF can starve.
- Defined: round-robin. When both are high, grant the one not granted last.
  - A single requester is always granted.
  - The pointer updates on every grant and resets to "IF last", so MEM wins the first tie.

## Structure

- Shared defines/package holds:
  - state encodings (IDLE/RD/WR/FIN);
  - mem_len codes (LEN_B/LEN_H/LEN_W);
  - requester ids (REQ_IF/REQ_MEM).
- One sub-module is natural: mem_arb_grant.
  - Combinational winner select plus the registered RR pointer.
  - Only the pointer and its `ifdef` live inside it.
- The byte sequencer and assembler stay in mem_arbiter.

## Test plan

- **IF word read:** if_req = 1, if_addr = 0x100, RAM[0x100..0x103] = 13 00 00 93.
  - ram_addr 0x100..0x103 in cycles 1-4.
  - if_done in cycle 6 with if_rdata = 0x9300_0013.
  - stallreq_if high for cycles 0-5.
- **MEM byte store:** mem_we = 1, mem_len = 00, addr 0x2003, wdata 0xAABBCCDD.
  - Single ram_we cycle with ram_dout = 0xDD at 0x2003.
  - mem_done in cycle 2.
- **Half load:** mem_len = 01, addr 0x10 with bytes 34 12.
  - mem_rdata = 0x0000_1234; done in cycle 4.
- **Tie:** both requests high from reset, IF at 0x0, MEM word load at 0x40.
  - Fixed mode: MEM, MEM... while mem_req stays high.
  - MEM_ARB_RR_EN: grants alternate MEM, IF, MEM; each done matches its own data.
- **Wrap:** word read at 0xFFFF_FFFE.
  - ram_addr sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- **Reset mid-store:** drop rst_n in cycle 2 of a word store.
  - Outputs 0 immediately; no mem_done.
  - After release, a new IF request completes normally in 6 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//
// Shared definitions for the IF/MEM byte-port arbiter:
//   - arb_state_t : sequencer states (IDLE / RD / WR / FIN)
//   - LEN_B/H/W   : mem_len codes (2'b11 is also treated as a word)
//   - REQ_IF/MEM  : requester ids latched at grant
//   - len_to_bytes: mem_len code -> number of byte cycles (1/2/4)
//
// No ports (package only).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } arb_state_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    // Instruction fetches are always 4 bytes; only MEM uses this.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;   // LEN_W and 2'b11
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
//
// Winner select between the IF and MEM requesters. The select is purely
// combinational; the parent only acts on it while its sequencer is idle and
// tells this block that a grant was taken through grant_take.
//
// Configuration macro: MEM_ARB_RR_EN
//   undefined : fixed priority, MEM beats IF on a tie (IF can starve).
//   defined   : round-robin, a tie goes to the requester not granted last.
//               The pointer resets to "IF last", so MEM wins the first tie.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset (pointer only)
//   if_req       in   IF request
//   mem_req      in   MEM request
//   grant_take   in   parent accepted the grant at this edge
//   grant_valid  out  at least one requester is asking
//   grant_id     out  winning requester (REQ_IF / REQ_MEM)
// -----------------------------------------------------------------------------
module mem_arb_grant (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic mem_req,
    input  logic grant_take,
    output logic grant_valid,
    output logic grant_id
);
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
    // Id of the requester that received the most recent grant.
    logic last_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_reg <= REQ_IF;
        end else if (grant_take) begin
            last_id_reg <= grant_id;
        end
    end

    always_comb begin
        grant_valid = if_req | mem_req;
        grant_id    = REQ_IF;
        if (if_req && mem_req) begin
            grant_id = (last_id_reg == REQ_IF) ? REQ_MEM : REQ_IF;
        end else if (mem_req) begin
            grant_id = REQ_MEM;
        end
    end
`else
    always_comb begin
        grant_valid = if_req | mem_req;
        grant_id    = mem_req ? REQ_MEM : REQ_IF;
    end

    // Fixed priority keeps no state, so these inputs have no load here.
    logic unused_rr;
    assign unused_rr = &{1'b0, clk, rst_n, grant_take};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide synchronous RAM port between instruction fetch (IF)
// and load/store (MEM). Each 8/16/32-bit access is serialised into byte
// cycles; read bytes are assembled little-endian and zero-extended.
//
// Sequencer: IDLE (arbitrate) -> RD or WR (one byte per cycle) -> FIN
// (one-cycle done pulse) -> IDLE. Requests are only sampled in IDLE.
//
// Timing from the IDLE cycle in which the request is sampled (cycle 0):
//   n-byte read : addresses in cycles 1..n, done in cycle n+2
//   n-byte write: ram_we in cycles 1..n,    done in cycle n+1
//
// Configuration macro: MEM_ARB_RR_EN (round-robin arbitration, handled in
// mem_arb_grant). Default build is fixed priority with MEM first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        IF word-read request (held until if_done)
//   if_rdata/if_done      fetched word, valid during the if_done pulse
//   mem_req/we/len/addr   MEM request (held until mem_done)
//   mem_wdata             store data, low byte first
//   mem_rdata/mem_done    load data (zero-extended), valid during mem_done
//   ram_addr/dout/we      byte RAM port outputs
//   ram_din               RAM read byte, one cycle after ram_addr
//   stallreq_if/mem       x_req & ~x_done, forced low in reset
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              stallreq_if,
    output logic              stallreq_mem
);
    import mem_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic              id_reg;          // requester latched at grant
    logic [2:0]        n_reg;           // byte count latched at grant
    logic [2:0]        cnt_reg;         // cycles spent in RD/WR so far
    logic [23:0]       wdata_sh_reg;    // store bytes not yet on ram_dout
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]        ram_dout_reg;
    logic [7:0]        lane_reg [4];    // assembled read bytes

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic grant_valid;
    logic grant_id;
    logic grant_take;
    logic grant_is_wr;

    assign grant_take  = (state_reg == ST_IDLE) && grant_valid;
    assign grant_is_wr = (grant_id == REQ_MEM) && mem_we;

    mem_arb_grant u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .mem_req     (mem_req),
        .grant_take  (grant_take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // ------------------------------------------------------------------
    // Sequencer control
    // ------------------------------------------------------------------
    logic       in_rw;
    logic       addr_step;
    logic       rd_capture;
    logic [1:0] cap_idx;

    // RD/WR cycle cnt drives byte cnt; the address register is advanced
    // one edge early so ram_addr is already base+cnt in that cycle.
    assign in_rw     = (state_reg == ST_RD) || (state_reg == ST_WR);
    assign addr_step = in_rw && ((cnt_reg + 3'd1) < n_reg);

    // ram_din lags the address by a cycle, so RD cycle cnt (>0) returns
    // byte cnt-1. RD therefore lasts n+1 cycles. cnt==4 wraps to lane 3.
    assign rd_capture = (state_reg == ST_RD) && (cnt_reg != 3'd0);
    assign cap_idx    = cnt_reg[1:0] - 2'd1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = grant_is_wr ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_reg == n_reg) begin
                    state_next = ST_FIN;
                end
            end
            ST_WR: begin
                if (cnt_reg == (n_reg - 3'd1)) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Transaction latch, byte counter and RAM port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg       <= REQ_IF;
            n_reg        <= 3'd0;
            cnt_reg      <= 3'd0;
            wdata_sh_reg <= 24'd0;
            ram_addr_reg <= '0;
            ram_dout_reg <= 8'd0;
        end else if (grant_take) begin
            id_reg       <= grant_id;
            n_reg        <= (grant_id == REQ_MEM) ? len_to_bytes(mem_len) : 3'd4;
            cnt_reg      <= 3'd0;
            ram_addr_reg <= (grant_id == REQ_MEM) ? mem_addr : if_addr;
            // Reads leave ram_dout at its previous value.
            if (grant_is_wr) begin
                ram_dout_reg <= mem_wdata[7:0];
                wdata_sh_reg <= mem_wdata[31:8];
            end
        end else if (in_rw) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (addr_step) begin
                ram_addr_reg <= ram_addr_reg + ADDR_ONE;
                if (state_reg == ST_WR) begin
                    ram_dout_reg <= wdata_sh_reg[7:0];
                    wdata_sh_reg <= {8'd0, wdata_sh_reg[23:8]};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read assembly: one byte lane per register, cleared at every grant so
    // bytes beyond the access length read back as zero.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg[gi] <= 8'd0;
                end else if (grant_take) begin
                    lane_reg[gi] <= 8'd0;
                end else if (rd_capture && (cap_idx == 2'(gi))) begin
                    lane_reg[gi] <= ram_din;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic        fin;
    logic [31:0] rdata_word;

    assign fin        = (state_reg == ST_FIN);
    assign rdata_word = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};

    assign if_done   = fin && (id_reg == REQ_IF);
    assign mem_done  = fin && (id_reg == REQ_MEM);
    assign if_rdata  = if_done  ? rdata_word : 32'd0;
    assign mem_rdata = mem_done ? rdata_word : 32'd0;

    assign ram_addr = ram_addr_reg;
    assign ram_dout = ram_dout_reg;
    // Decoded from state so an asynchronous reset stops writes at once.
    assign ram_we   = (state_reg == ST_WR);

    assign stallreq_if  = rst_n & if_req  & ~if_done;
    assign stallreq_mem = rst_n & mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. Requester tasks push expected done data
// (with due cycle), expected RAM writes and per-cycle expectations into
// queues; a monitor on the falling edge pops and compares them. A 64 KiB
// byte array indexed by ram_addr[15:0] models the synchronous RAM.
// Build with +define+MEM_ARB_RR_EN to exercise the round-robin variant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        stallreq_if;
    logic        stallreq_mem;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MEM_ARB_RR_EN
    localparam int IF_TIE_LAT   = 13;
    localparam int MEM2_TIE_LAT = 13;
`else
    localparam int IF_TIE_LAT   = 20;
    localparam int MEM2_TIE_LAT = 6;
`endif

    // ---------------- RAM model ----------------
    logic [7:0] ram_mem [0:65535];
    bit         loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            ram_mem[16'h0000] <= 8'h78; ram_mem[16'h0001] <= 8'h56;
            ram_mem[16'h0002] <= 8'h34; ram_mem[16'h0003] <= 8'h12;
            ram_mem[16'h0010] <= 8'h34; ram_mem[16'h0011] <= 8'h12;
            ram_mem[16'h0040] <= 8'h11; ram_mem[16'h0041] <= 8'h22;
            ram_mem[16'h0042] <= 8'h33; ram_mem[16'h0043] <= 8'h44;
            ram_mem[16'h0100] <= 8'h13; ram_mem[16'h0101] <= 8'h00;
            ram_mem[16'h0102] <= 8'h00; ram_mem[16'h0103] <= 8'h93;
            ram_mem[16'h5000] <= 8'hEE; ram_mem[16'h5001] <= 8'hEE;
            ram_mem[16'h5002] <= 8'hEE; ram_mem[16'h5003] <= 8'hEE;
            ram_mem[16'hFFFE] <= 8'hAA; ram_mem[16'hFFFF] <= 8'hBB;
            ram_din <= 8'h00;
            loaded  <= 1'b1;
        end else begin
            ram_din <= ram_mem[ram_addr[15:0]];
            if (ram_we) ram_mem[ram_addr[15:0]] <= ram_dout;
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct { logic [31:0] data; int due; bit chk_data; } done_exp_t;
    typedef struct { int cyc; int kind; logic [31:0] val; } tchk_t;
    typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_exp_t;

    done_exp_t if_q[$];
    done_exp_t mem_q[$];
    tchk_t     chk_q[$];
    wr_exp_t   wr_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: actual %h, required %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s @cycle %0d", name, cyc);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        done_exp_t d;
        wr_exp_t   w;
        #1;
        if (if_done) begin
            $display("[%0d] IF  done rdata=%h", cyc, if_rdata);
            if (if_q.size() == 0) fail_event("if_done_unexpected");
            else begin
                d = if_q.pop_front();
                if (d.chk_data) check("if_rdata", if_rdata, d.data);
                check("if_done_cycle", cyc, d.due);
            end
        end
        if (mem_done) begin
            $display("[%0d] MEM done rdata=%h", cyc, mem_rdata);
            if (mem_q.size() == 0) fail_event("mem_done_unexpected");
            else begin
                d = mem_q.pop_front();
                if (d.chk_data) check("mem_rdata", mem_rdata, d.data);
                check("mem_done_cycle", cyc, d.due);
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) fail_event("ram_we_unexpected");
            else begin
                w = wr_q.pop_front();
                check("wr_addr", ram_addr, w.addr);
                check("wr_dout", {24'd0, ram_dout}, {24'd0, w.data});
                check("wr_cycle", cyc, w.cyc);
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                case (chk_q[i].kind)
                    0:       check("ram_addr", ram_addr, chk_q[i].val);
                    1:       check("stallreq_if", {31'd0, stallreq_if}, chk_q[i].val);
                    default: check("stallreq_mem", {31'd0, stallreq_mem}, chk_q[i].val);
                endcase
                chk_q.delete(i);
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic do_if(input logic [31:0] addr, input logic [31:0] exp,
                         input int lat, input bit timed);
        int start;
        bit seen;
        @(negedge clk);
        start   = cyc;
        if_addr = addr;
        if_req  = 1'b1;
        if_q.push_back('{data: exp, due: start + lat, chk_data: 1'b1});
        if (timed) begin
            for (int k = 0; k < 4; k++)
                chk_q.push_back('{cyc: start + 1 + k, kind: 0, val: addr + 32'(k)});
            for (int c = 0; c < lat; c++)
                chk_q.push_back('{cyc: start + c, kind: 1, val: 32'd1});
            chk_q.push_back('{cyc: start + lat, kind: 1, val: 32'd0});
        end
        seen = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (if_done) begin
                seen = 1'b1;
                break;
            end
        end
        if_req = 1'b0;
        if (!seen) fail_event("if_timeout");
    endtask

    task automatic do_mem(input logic we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input int lat,
                          input bit timed, input bit chkd);
        int start;
        int n;
        bit seen;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        @(negedge clk);
        start     = cyc;
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_req   = 1'b1;
        mem_q.push_back('{data: exp, due: start + lat, chk_data: chkd});
        if (we) begin
            for (int k = 0; k < n; k++)
                wr_q.push_back('{cyc: start + 1 + k, addr: addr + 32'(k),
                                 data: wdata[8*k +: 8]});
        end
        if (timed) begin
            if (!we) begin
                for (int k = 0; k < n; k++)
                    chk_q.push_back('{cyc: start + 1 + k, kind: 0, val: addr + 32'(k)});
            end
            for (int c = 0; c < lat; c++)
                chk_q.push_back('{cyc: start + c, kind: 2, val: 32'd1});
            chk_q.push_back('{cyc: start + lat, kind: 2, val: 32'd0});
        end
        seen = 1'b0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (mem_done) begin
                seen = 1'b1;
                break;
            end
        end
        mem_req = 1'b0;
        if (!seen) fail_event("mem_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_if_rdata"},  if_rdata,  32'd0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        check({tag, "_if_done"},   {31'd0, if_done},  32'd0);
        check({tag, "_mem_done"},  {31'd0, mem_done}, 32'd0);
        check({tag, "_ram_addr"},  ram_addr,  32'd0);
        check({tag, "_ram_dout"},  {24'd0, ram_dout}, 32'd0);
        check({tag, "_ram_we"},    {31'd0, ram_we},   32'd0);
        check({tag, "_stall_if"},  {31'd0, stallreq_if},  32'd0);
        check({tag, "_stall_mem"}, {31'd0, stallreq_mem}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int start;
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_len   = 2'b10;
        mem_addr  = 32'h40;
        mem_wdata = 32'h0;

        // Reset: outputs zero, stall requests forced low despite requests.
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie from reset: IF at 0x0 against two MEM word loads at 0x40.
        fork
            do_if(32'h0000_0000, 32'h1234_5678, IF_TIE_LAT, 1'b0);
            begin
                do_mem(1'b0, 2'b10, 32'h40, 32'h0, 32'h4433_2211, 6, 1'b0, 1'b1);
                do_mem(1'b0, 2'b10, 32'h40, 32'h0, 32'h4433_2211, MEM2_TIE_LAT, 1'b0, 1'b1);
            end
        join

        // IF word read, addresses 0x100..0x103 in cycles 1-4, done cycle 6.
        do_if(32'h0000_0100, 32'h9300_0013, 6, 1'b1);
        // MEM byte store: one write of 0xDD at 0x2003, done cycle 2.
        do_mem(1'b1, 2'b00, 32'h2003, 32'hAABB_CCDD, 32'h0, 2, 1'b1, 1'b0);
        // Half load at 0x10: 34 12 -> 0x1234, done cycle 4.
        do_mem(1'b0, 2'b01, 32'h10, 32'h0, 32'h0000_1234, 4, 1'b1, 1'b1);
        // Byte load of the stored byte, upper bytes zero, done cycle 3.
        do_mem(1'b0, 2'b00, 32'h2003, 32'h0, 32'h0000_00DD, 3, 1'b1, 1'b1);
        // Word store then word load at 0x3000.
        do_mem(1'b1, 2'b10, 32'h3000, 32'h0403_0201, 32'h0, 5, 1'b1, 1'b0);
        do_mem(1'b0, 2'b10, 32'h3000, 32'h0, 32'h0403_0201, 6, 1'b1, 1'b1);
        // Wrapping word load (len 11): FFFE, FFFF, 0000, 0001 -> AA BB 78 56.
        do_mem(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 32'h5678_BBAA, 6, 1'b1, 1'b1);

        // Reset in cycle 2 of a word store: only byte 0 reaches the RAM.
        @(negedge clk);
        start     = cyc;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h5000;
        mem_wdata = 32'h1122_3344;
        mem_req   = 1'b1;
        wr_q.push_back('{cyc: start + 1, addr: 32'h5000, data: 8'h44});
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("ram_5000_written", {24'd0, ram_mem[16'h5000]}, 32'h44);
        check("ram_5001_untouched", {24'd0, ram_mem[16'h5001]}, 32'hEE);

        // Normal IF read after reset release.
        do_if(32'h0000_0100, 32'h9300_0013, 6, 1'b1);

        repeat (4) @(negedge clk);
        #2;
        check("if_q_left",  if_q.size(),  32'd0);
        check("mem_q_left", mem_q.size(), 32'd0);
        check("wr_q_left",  wr_q.size(),  32'd0);
        check("chk_q_left", chk_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
